// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin byte scheduler feeding a serial transmitter.
// A free-running divider produces the baud tick. A three-state FSM grants
// one of four requesters, presents the byte with tx_enable until the
// transmitter samples it on a tick, then holds off new grants for
// HOLD_TICKS ticks while the frame is shifted out.
module tx_scheduler #(
  parameter int DIVISOR    = 16,
  parameter int HOLD_TICKS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  output logic        tick,
  output logic        tx_enable,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam logic [15:0] DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  txd_q, txd_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  gid_q, gid_d;
  logic        tick_w;
  logic        found;
  logic [1:0]  win;
  logic [1:0]  idx;

  assign tick_w = (div_q == DIV_LAST);

  // Baud divider: free-running, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick_w) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  // Round-robin arbiter: search starts just after the last granted index.
  always_comb begin
    found = 1'b0;
    win   = gid_q;
    idx   = gid_q;
    for (int k = 1; k <= 4; k++) begin
      idx = gid_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, wait for the sampling tick in LOAD,
  // count out the frame in WAIT.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    txd_d   = txd_q;
    ack_d   = 4'b0000;
    gid_d   = gid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          txd_d   = data_in[{win, 3'b000} +: 8];
          ack_d   = 4'b0001 << win;
          gid_d   = win;
        end
      end
      LOAD: begin
        if (tick_w) begin
          state_d = WAIT;
          tcnt_d  = 8'd0;
        end
      end
      WAIT: begin
        if (tick_w) begin
          if (tcnt_q == HOLD_LAST) begin
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tcnt_q  <= 8'd0;
      txd_q   <= 8'h00;
      ack_q   <= 4'b0000;
      gid_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      txd_q   <= txd_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
    end
  end

  assign tick      = tick_w;
  assign tx_enable = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign tx_data   = txd_q;
  assign ack       = ack_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a frame-timeline model.
module tb_tx_scheduler;

  localparam int DIV  = 4;
  localparam int HOLD = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        tick;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  tx_scheduler #(.DIVISOR(DIV), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .tick(tick), .tx_enable(tx_enable), .tx_data(tx_data), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycle index since reset release, plus the timeline of the
  // current frame (grant cycle, LOAD-tick cycle, first IDLE cycle).
  int         cyc;
  bit         in_frame;
  int         g_cyc, t1_cyc, end_cyc;
  logic [7:0] m_txd;
  int         m_gid;
  bit         drop_mode;
  int         glog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_idle();
    return !in_frame || cyc >= end_cyc;
  endfunction

  // One clock cycle: check outputs at negedge, advance the model, then
  // move to just after the next rising edge.
  task automatic step();
    logic [3:0] a_exp;
    bit e_tick, e_busy, e_en;
    int w;
    @(negedge clk);
    e_tick = ((cyc % DIV) == DIV - 1);
    e_busy = in_frame && cyc < end_cyc;
    e_en   = in_frame && cyc > g_cyc && cyc <= t1_cyc;
    a_exp  = (in_frame && cyc == g_cyc + 1) ? (4'b0001 << m_gid) : 4'b0000;
    check("tick", tick, e_tick);
    check("busy", busy, e_busy);
    check("tx_enable", tx_enable, e_en);
    check("ack", ack, a_exp);
    check("tx_data", tx_data, m_txd);
    check("grant_id", grant_id, m_gid);
    if (!e_busy && req != 4'b0000) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        if (w < 0 && req[(m_gid + k) % 4]) w = (m_gid + k) % 4;
      end
      m_gid    = w;
      m_txd    = data_in[8*w +: 8];
      g_cyc    = cyc;
      t1_cyc   = cyc + 1 + ((DIV - 1 - ((cyc + 1) % DIV)) % DIV);
      end_cyc  = t1_cyc + HOLD * DIV + 1;
      in_frame = 1'b1;
      glog.push_back(w);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (drop_mode) req = req & ~a_exp;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Synchronous reset pulse; checks reset values right after the edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_enable", tx_enable, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_ack", ack, 4'b0000);
    check("rst_grant_id", grant_id, 2'd3);
    check("rst_tcnt", dut.tcnt_q, 8'd0);
    reset    = 1'b0;
    cyc      = 0;
    in_frame = 1'b0;
    g_cyc    = -10;
    t1_cyc   = -10;
    end_cyc  = -10;
    m_txd    = 8'h00;
    m_gid    = 3;
  endtask

  initial begin
    int en_cnt, wait_cnt, bound;
    reset = 1'b1;
    req = 4'b0000;
    data_in = 32'h0;
    drop_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: idle divider.
    do_reset();
    run(20);

    // Test 2: single request, measure LOAD and WAIT lengths.
    do_reset();
    data_in = 32'h000000A5;
    req = 4'b0001;
    wait_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy && !tx_enable) wait_cnt++;
      step();
    end
    check("t2_wait_len", wait_cnt, HOLD * DIV);
    check("t2_tx_data", tx_data, 8'hA5);

    // Test 3: all requesters held, round-robin order.
    do_reset();
    drop_mode = 1'b0;
    glog.delete();
    data_in = 32'h44332211;
    req = 4'b1111;
    run(5 * (HOLD * DIV + DIV + 2));
    req = 4'b0000;
    drop_mode = 1'b1;
    run(HOLD * DIV + 2 * DIV);
    if (glog.size() >= 5) begin
      check("t3_g0", glog[0], 0);
      check("t3_g1", glog[1], 1);
      check("t3_g2", glog[2], 2);
      check("t3_g3", glog[3], 3);
      check("t3_g4", glog[4], 0);
    end else begin
      check("t3_grant_count", glog.size(), 5);
    end

    // Test 4: req[0] raised mid-frame waits for IDLE, then wins after 2.
    do_reset();
    glog.delete();
    data_in = 32'hDEADBEEF;
    req = 4'b0100;
    run(12);
    req = req | 4'b0001;
    run(2 * (HOLD * DIV + 2 * DIV));
    check("t4_grants", glog.size(), 2);
    check("t4_gid", grant_id, 2'd0);

    // Test 5: reset in WAIT with tcnt=7, pending req[1] served after.
    do_reset();
    data_in = 32'h12345678;
    req = 4'b0001;
    step();
    req = req | 4'b0010;
    bound = 0;
    while (cyc < t1_cyc + 7 * DIV + 1 && bound < 1000) begin
      step();
      bound++;
    end
    check("t5_tcnt_before", dut.tcnt_q, 8'd7);
    check("t5_busy_before", busy, 1'b1);
    glog.delete();
    do_reset();
    run(8);
    check("t5_regrant", glog.size() > 0 ? glog[0] : -1, 1);
    run(HOLD * DIV + 2 * DIV);

    // Test 6: grant on a tick cycle; that tick is ignored.
    do_reset();
    req = 4'b0000;
    bound = 0;
    while (!(m_idle() && (cyc % DIV) == DIV - 1) && bound < 1000) begin
      step();
      bound++;
    end
    data_in = 32'h9C000000;
    req = 4'b1000;
    en_cnt = 0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      if (tx_enable) en_cnt++;
      step();
    end
    check("t6_load_len", en_cnt, DIV);
    run(HOLD * DIV + DIV);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      data_in = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
